bus_cycle_arbiter: RTL and testbench

BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

---
 rtl/bus_cycle_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bus_cycle_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_arbiter.sv
// External bus cycle sequencer: CPU cycles run SETUP/STROBE/HOLD with WAIT extension
// and timeout; a DMA master can take the bus between cycles.
module bus_cycle_arbiter #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_mem_io,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        bus_err,
  input  logic        dma_req,
  output logic        dma_ack,
  input  logic        WAIT,
  input  logic [7:0]  data_in,
  output logic [21:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rd,
  output logic        wr,
  output logic        mem_io
);

  // state  | meaning
  // IDLE   | bus parked, addr/mem_io hold last value
  // SETUP  | address/data valid, strobes low (1 cycle)
  // STROBE | rd or wr active, extended by WAIT up to the timeout
  // HOLD   | strobes low, cpu_ack/bus_err pulse (1 cycle)
  // GRANT  | bus released to the DMA master
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GRANT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        tout_q, tout_d;
  logic        favor_q, favor_d;
  logic [21:0] addr_d;
  logic [7:0]  data_out_d, rdata_d;
  logic        data_oe_d, rd_d, wr_d, mem_io_d, ack_d, err_d, dma_ack_d;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      wcnt_q    <= 8'd0;
      tout_q    <= 1'b0;
      favor_q   <= 1'b0;
      addr      <= 22'd0;
      data_out  <= 8'd0;
      data_oe   <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      mem_io    <= 1'b0;
      cpu_ack   <= 1'b0;
      bus_err   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= 8'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wcnt_q    <= wcnt_d;
      tout_q    <= tout_d;
      favor_q   <= favor_d;
      addr      <= addr_d;
      data_out  <= data_out_d;
      data_oe   <= data_oe_d;
      rd        <= rd_d;
      wr        <= wr_d;
      mem_io    <= mem_io_d;
      cpu_ack   <= ack_d;
      bus_err   <= err_d;
      dma_ack   <= dma_ack_d;
      cpu_rdata <= rdata_d;
    end
  end

  // Outputs are computed for the state being entered so every pin comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    wcnt_d     = wcnt_q;
    tout_d     = tout_q;
    favor_d    = favor_q;
    addr_d     = addr;
    data_out_d = data_out;
    data_oe_d  = data_oe;
    mem_io_d   = mem_io;
    rdata_d    = cpu_rdata;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dma_ack_d  = 1'b0;

    case (state_q)
      IDLE: begin
        favor_d = 1'b0;
        if (dma_req && !(cpu_req && favor_q)) begin
          state_d    = GRANT;
          dma_ack_d  = 1'b1;
          addr_d     = 22'd0;
          data_out_d = 8'd0;
          data_oe_d  = 1'b0;
          mem_io_d   = 1'b0;
        end else if (cpu_req) begin
          state_d    = SETUP;
          we_d       = cpu_we;
          addr_d     = cpu_addr;
          mem_io_d   = cpu_mem_io;
          data_out_d = cpu_wdata;
          data_oe_d  = cpu_we;
          wcnt_d     = 8'd0;
          tout_d     = 1'b0;
        end
      end
      SETUP: begin
        state_d = STROBE;
        rd_d    = ~we_q;
        wr_d    = we_q;
      end
      STROBE: begin
        if (WAIT) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q + 8'd1 == TIMEOUT) begin
            state_d = HOLD;
            tout_d  = 1'b1;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            if (!we_q) rdata_d = 8'hFF;
          end else begin
            rd_d = ~we_q;
            wr_d = we_q;
          end
        end else begin
          state_d = HOLD;
          ack_d   = 1'b1;
          err_d   = tout_q;
          if (!we_q) rdata_d = data_in;
        end
      end
      HOLD: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
      GRANT: begin
        if (dma_req) begin
          dma_ack_d = 1'b1;
        end else begin
          state_d = IDLE;
          favor_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter: directed scenarios plus randomized CPU cycles
// checked against a transaction-level timing model (default and 4-cycle timeout instances).
module tb_bus_cycle_arbiter;
  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_mem_io = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        dma_req = 1'b0, WAIT = 1'b0;
  logic [7:0]  data_in = '0;

  logic [7:0]  cpu_rdata, t4_cpu_rdata;
  logic        cpu_ack, bus_err, dma_ack, data_oe, rd, wr, mem_io;
  logic        t4_cpu_ack, t4_bus_err, t4_dma_ack, t4_data_oe, t4_rd, t4_wr, t4_mem_io;
  logic [21:0] addr, t4_addr;
  logic [7:0]  data_out, t4_data_out;

  int checks = 0, errors = 0;
  logic [7:0] model_rd = 8'd0, model_rd4 = 8'd0;

  bus_cycle_arbiter dut (
    .clk(clk), .arst(arst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mem_io(cpu_mem_io),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .bus_err(bus_err), .dma_req(dma_req), .dma_ack(dma_ack), .WAIT(WAIT), .data_in(data_in),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .rd(rd), .wr(wr), .mem_io(mem_io));

  bus_cycle_arbiter #(.WAIT_TIMEOUT(4)) dut4 (
    .clk(clk), .arst(arst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mem_io(cpu_mem_io),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(t4_cpu_rdata), .cpu_ack(t4_cpu_ack),
    .bus_err(t4_bus_err), .dma_req(dma_req), .dma_ack(t4_dma_ack), .WAIT(WAIT), .data_in(data_in),
    .addr(t4_addr), .data_out(t4_data_out), .data_oe(t4_data_oe), .rd(t4_rd), .wr(t4_wr),
    .mem_io(t4_mem_io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 arst = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; WAIT = 1'b0;
    model_rd = 8'd0; model_rd4 = 8'd0;
    tick();
    arst = 1'b1;
  endtask

  // One CPU cycle; the expected shape comes from the timing rules:
  // SETUP(1) + STROBE(min(nwait+1, timeout)) + HOLD(1), ack in the HOLD cycle.
  task automatic cpu_txn(input bit sel4, input logic we, input logic mio, input logic [21:0] a,
                         input logic [7:0] wd, input int nwait, input logic [7:0] din);
    int to, strobe, nrd, nwr, noe, ack_at;
    bit exp_err, got_err, acked;
    logic [7:0] exp_rd;
    to      = sel4 ? 4 : 255;
    exp_err = (nwait >= to);
    strobe  = exp_err ? to : nwait + 1;
    exp_rd  = sel4 ? model_rd4 : model_rd;
    if (!we) exp_rd = exp_err ? 8'hFF : din;
    if (sel4) model_rd4 = exp_rd; else model_rd = exp_rd;
    nrd = 0; nwr = 0; noe = 0; ack_at = 0; got_err = 1'b0; acked = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_mem_io = mio; cpu_addr = a; cpu_wdata = wd;
    data_in = din; WAIT = 1'b0;
    for (int k = 1; k <= 300 && !acked; k++) begin
      tick();
      if (k == 1) begin
        cpu_addr = 22'($urandom); cpu_we = ~we; cpu_mem_io = ~mio; cpu_wdata = 8'($urandom);
      end
      WAIT = (k >= 2 && k <= 1 + nwait);
      if (sel4 ? t4_rd : rd) nrd++;
      if (sel4 ? t4_wr : wr) nwr++;
      if (sel4 ? t4_data_oe : data_oe) noe++;
      if (sel4 ? t4_cpu_ack : cpu_ack) begin
        acked   = 1'b1;
        ack_at  = k;
        got_err = sel4 ? t4_bus_err : bus_err;
        chk("hold_addr", 32'(sel4 ? t4_addr : addr), 32'(a));
        chk("hold_mem_io", 32'(sel4 ? t4_mem_io : mem_io), 32'(mio));
        if (we) chk("hold_data_out", 32'(sel4 ? t4_data_out : data_out), 32'(wd));
        chk("cpu_rdata", 32'(sel4 ? t4_cpu_rdata : cpu_rdata), 32'(exp_rd));
        cpu_req = 1'b0;
      end
    end
    WAIT = 1'b0;
    chk("ack_seen", 32'(acked), 32'd1);
    chk("ack_latency", 32'(ack_at), 32'(strobe + 2));
    chk("bus_err", 32'(got_err), 32'(exp_err));
    chk("rd_cycles", 32'(nrd), we ? 32'd0 : 32'(strobe));
    chk("wr_cycles", 32'(nwr), we ? 32'(strobe) : 32'd0);
    chk("oe_cycles", 32'(noe), we ? 32'(strobe + 2) : 32'd0);
    tick();
    chk("idle_no_ack", 32'(sel4 ? t4_cpu_ack : cpu_ack), 32'd0);
    chk("idle_oe", 32'(sel4 ? t4_data_oe : data_oe), 32'd0);
  endtask

  initial begin
    logic [21:0] ra;
    logic        rwe, rmio;
    logic [7:0]  rwd, rdin;
    int          rnw;

    tick(); tick();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_rd_wr", 32'({rd, wr, data_oe, mem_io}), 32'd0);
    chk("rst_acks", 32'({cpu_ack, bus_err, dma_ack}), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    arst = 1'b1;
    tick();

    // Timeout instance: stuck WAIT read, then random cycles straddling the timeout.
    cpu_txn(1'b1, 1'b0, 1'b1, 22'h2AAAAA, 8'h00, 1000, 8'h11);
    tick(); tick(); tick(); tick(); tick(); tick();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rwe = 1'($urandom); rmio = 1'($urandom); ra = 22'($urandom);
      rwd = 8'($urandom); rdin = 8'($urandom); rnw = int'($urandom_range(0, 6));
      cpu_txn(1'b1, rwe, rmio, ra, rwd, rnw, rdin);
    end

    // Default instance: directed read and waited IO write, then random traffic.
    do_reset();
    cpu_txn(1'b0, 1'b0, 1'b1, 22'h012345, 8'h00, 0, 8'hA5);
    cpu_txn(1'b0, 1'b1, 1'b0, 22'h000777, 8'h3C, 4, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dma_req = 1'b1;
        tick();
        chk("rnd_dma_ack", 32'(dma_ack), 32'd1);
        chk("rnd_dma_bus", 32'({addr, data_oe, mem_io, rd, wr}), 32'd0);
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
        dma_req = 1'b0;
        tick();
        chk("rnd_dma_drop", 32'(dma_ack), 32'd0);
      end
      rwe = 1'($urandom); rmio = 1'($urandom); ra = 22'($urandom);
      rwd = 8'($urandom); rdin = 8'($urandom); rnw = int'($urandom_range(0, 6));
      cpu_txn(1'b0, rwe, rmio, ra, rwd, rnw, rdin);
    end

    // DMA raised mid-STROBE; after release the waiting CPU wins over a re-asserted dma_req.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mem_io = 1'b1; cpu_addr = 22'h155555; data_in = 8'h5A;
    tick();
    tick(); dma_req = 1'b1;
    tick();
    chk("dma_mid_ack", 32'(cpu_ack), 32'd1);
    chk("dma_mid_no_grant", 32'(dma_ack), 32'd0);
    chk("dma_mid_rdata", 32'(cpu_rdata), 32'h5A);
    tick();
    chk("dma_idle", 32'({dma_ack, cpu_ack}), 32'd0);
    tick();
    chk("dma_grant", 32'(dma_ack), 32'd1);
    chk("dma_grant_bus", 32'({addr, data_oe, rd, wr, mem_io}), 32'd0);
    tick();
    chk("dma_stay", 32'(dma_ack), 32'd1);
    dma_req = 1'b0;
    tick();
    chk("dma_release", 32'(dma_ack), 32'd0);
    dma_req = 1'b1;
    tick();
    chk("starve_cpu_first", 32'(dma_ack), 32'd0);
    chk("starve_addr", 32'(addr), 32'h155555);
    tick();
    chk("starve_rd", 32'(rd), 32'd1);
    tick();
    chk("starve_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();
    tick();
    chk("regrant", 32'(dma_ack), 32'd1);
    dma_req = 1'b0;
    tick();

    // Both requesting straight out of reset: DMA wins.
    do_reset();
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 22'h3FFFFF;
    tick();
    chk("both_dma_ack", 32'(dma_ack), 32'd1);
    chk("both_bus", 32'({addr, data_oe}), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // Async reset in the STROBE of a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mem_io = 1'b1; cpu_addr = 22'h0ABCDE; cpu_wdata = 8'hC3;
    tick();
    tick();
    chk("pre_rst_wr", 32'({wr, data_oe}), 32'd3);
    #2 arst = 1'b0;
    #1;
    chk("rst_wr_oe", 32'({wr, rd, data_oe}), 32'd0);
    chk("rst_bus", 32'({addr, data_out, mem_io}), 32'd0);
    chk("rst_no_ack", 32'({cpu_ack, bus_err, dma_ack}), 32'd0);
    cpu_addr = 22'h001234; cpu_we = 1'b0;
    tick();
    arst = 1'b1;
    tick();
    chk("post_rst_setup", 32'(addr), 32'h001234);
    chk("post_rst_no_ack", 32'(cpu_ack), 32'd0);
    tick();
    tick();
    chk("post_rst_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
